division_sequencer: RTL and testbench

//  Upstream issue stage for the iterative CLA fixed-point divider in the ODE solver datapath.

---
 rtl/division_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 48 ++++
 rtl/division_sequencer.sv | 123 ++++++++++++
 tb/tb_division_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/division_pkg.sv
// Shared constants and types for the divider issue stage.
// Operands use Q format: [15:13] scale factor, [12:0] two's-complement mantissa.
package division_pkg;

    localparam int N          = 16;
    localparam int SCALE_BITS = 3;
    localparam int MANT_BITS  = N - SCALE_BITS;
    localparam int STATUS_W   = 3;

    // Bit positions inside out_status
    localparam int ST_OVF = 0;
    localparam int ST_DBZ = 1;
    localparam int ST_TMO = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-around pointers (extra MSB distinguishes full from empty).
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/division_sequencer.sv
// Issue stage for the iterative fixed-point divider: buffers operand pairs, runs one
// division at a time, and hands back quotients in order on a valid/ready output.
module division_sequencer
    import division_pkg::*;
#(
    parameter int N          = division_pkg::N,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 40
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N-1:0]                  in_dividend,
    input  logic [N-1:0]                  in_divisor,
    output logic                          div_start,
    output logic [N-1:0]                  div_dividend,
    output logic [N-1:0]                  div_divisor,
    input  logic [N-1:0]                  div_q,
    input  logic                          div_ready,
    input  logic                          div_overflow,
    input  logic                          div_div_by_zero,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N-1:0]                  out_q,
    output logic [2:0]                    out_status,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   pending_count
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      wait_cnt;
    logic [2*N-1:0]     fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               cap;
    logic [N-1:0]       cap_q;
    logic [2:0]         cap_status;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    sync_fifo #(
        .WIDTH (2*N),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({in_dividend, in_divisor}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pending_count)
    );

    // Reset also holds the divider in reset so nothing in flight survives.
    assign div_start = reset || (state == LOAD);
    assign out_valid = (state == RESULT);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        cap        = 1'b0;
        cap_q      = '0;
        cap_status = '0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = WAIT;
            WAIT: begin
                // First WAIT cycle may still see the previous op's done level.
                if (wait_cnt != '0 && div_ready) begin
                    cap                = 1'b1;
                    cap_status[ST_OVF] = div_overflow;
                    cap_status[ST_DBZ] = div_div_by_zero;
                    cap_q              = (div_overflow || div_div_by_zero) ? '0 : div_q;
                    state_nxt          = RESULT;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    cap                = 1'b1;
                    cap_status[ST_TMO] = 1'b1;
                    state_nxt          = RESULT;
                end
            end
            RESULT: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            out_q        <= '0;
            out_status   <= '0;
        end else begin
            state <= state_nxt;
            if (pop) {div_dividend, div_divisor} <= fifo_dout;
            if (state == LOAD)      wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + CW'(1);
            if (cap) begin
                out_q      <= cap_q;
                out_status <= cap_status;
            end
        end
    end

endmodule

// File: tb/tb_division_sequencer.sv
// Bench for division_sequencer with a behavioural 18-cycle divider; a scoreboard queue
// holds hand-computed {status, quotient} values that a monitor compares on each transfer.
module tb_division_sequencer;

    localparam int N       = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_dividend = '0;
    logic [15:0] in_divisor = '0;
    logic        div_start;
    logic [15:0] div_dividend;
    logic [15:0] div_divisor;
    logic [15:0] div_q = '0;
    logic        div_ready = 1'b0;
    logic        div_overflow = 1'b0;
    logic        div_div_by_zero = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_q;
    logic [2:0]  out_status;
    logic        busy;
    logic [2:0]  pending_count;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_out = 0;
    int          cyc = 0;
    int          dcnt = 0;
    logic        div_dead = 1'b0;
    logic [18:0] sb[$];

    division_sequencer #(.N(N), .FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_dividend     (in_dividend),
        .in_divisor      (in_divisor),
        .div_start       (div_start),
        .div_dividend    (div_dividend),
        .div_divisor     (div_divisor),
        .div_q           (div_q),
        .div_ready       (div_ready),
        .div_overflow    (div_overflow),
        .div_div_by_zero (div_div_by_zero),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_q           (out_q),
        .out_status      (out_status),
        .busy            (busy),
        .pending_count   (pending_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Returns {div_by_zero, overflow, quotient}; scale factor follows the dividend.
    function automatic logic [17:0] div_model(input logic [15:0] a, input logic [15:0] b);
        int am, bm, qq;
        logic [31:0] qv;
        am = int'($signed(a[12:0]));
        bm = int'($signed(b[12:0]));
        if (bm == 0) return {2'b10, 16'h0};
        qq = (am * (1 << a[15:13])) / bm;
        if (qq > 4095 || qq < -4096) return {2'b01, 16'h0};
        qv = qq;
        return {2'b00, a[15:13], qv[12:0]};
    endfunction

    always @(posedge clk) begin
        if (div_start) begin
            dcnt            <= 0;
            div_ready       <= 1'b0;
            div_q           <= '0;
            div_overflow    <= 1'b0;
            div_div_by_zero <= 1'b0;
        end else if (!div_ready && !div_dead) begin
            if (dcnt == 17) begin
                div_ready <= 1'b1;
                {div_div_by_zero, div_overflow, div_q} <= div_model(div_dividend, div_divisor);
            end else begin
                dcnt <= dcnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_chk++;
            n_out++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got status=%b q=%h, no result expected", out_status, out_q);
            end else if ({out_status, out_q} !== sb[0]) begin
                n_fail++;
                $display("FAIL result: got status=%b q=%h expected status=%b q=%h",
                         out_status, out_q, sb[0][18:16], sb[0][15:0]);
                void'(sb.pop_front());
            end else begin
                void'(sb.pop_front());
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [18:0] e);
        int i;
        in_dividend = a;
        in_divisor  = b;
        in_valid    = 1'b1;
        i = 0;
        while (!in_ready && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (!in_ready) begin
            chk("push_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            sb.push_back(e);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain(input string nm);
        int i;
        i = 0;
        while (sb.size() != 0 && i < 600) begin
            @(negedge clk);
            i++;
        end
        chk(nm, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_start(output int t);
        int i;
        i = 0;
        while (!div_start && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("div_start_seen", 32'(div_start), 32'd1);
        t = cyc;
    endtask

    initial begin
        int t0, t1, i;
        repeat (3) @(negedge clk);
        chk("reset_div_start", 32'(div_start), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_pending", 32'(pending_count), 32'd0);
        chk("reset_out_q", 32'(out_q), 32'd0);
        chk("reset_status", 32'(out_status), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_div_dividend", 32'(div_dividend), 32'd0);
        chk("reset_div_start_low", 32'(div_start), 32'd0);

        // 6.0/2.0 = 3.0, then -6.0/2.0 = -3.0
        push({3'd3, 13'd48}, {3'd3, 13'd16}, {3'b000, 3'd3, 13'd24});
        push({3'd3, 13'h1FD0}, {3'd3, 13'd16}, {3'b000, 3'd3, 13'h1FE8});
        drain("drain_basic");

        // Zero divisor reaches the divider untouched; the following op still completes.
        push({3'd3, 13'd48}, 16'h0000, {3'b010, 16'h0000});
        wait_start(t0);
        @(negedge clk);
        chk("div_divisor_zero_fwd", 32'(div_divisor), 32'd0);
        push({3'd2, 13'd20}, {3'd2, 13'd8}, {3'b000, 3'd2, 13'd10});
        drain("drain_div0");

        // Back-pressure: one pair in flight, four buffered, the sixth must wait.
        out_ready = 1'b0;
        push({3'd3, 13'd48}, {3'd3, 13'd16}, {3'b000, 3'd3, 13'd24});
        push({3'd3, 13'd8},  {3'd3, 13'd8},  {3'b000, 3'd3, 13'd8});
        push({3'd3, 13'd40}, {3'd3, 13'd16}, {3'b000, 3'd3, 13'd20});
        push({3'd3, 13'd24}, {3'd3, 13'd32}, {3'b000, 3'd3, 13'd6});
        push({3'd3, 13'd64}, {3'd3, 13'd4},  {3'b000, 3'd3, 13'd128});
        chk("full_pending", 32'(pending_count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        fork
            push({3'd3, 13'd4000}, {3'd3, 13'd1}, {3'b001, 16'h0000});
            begin
                repeat (40) @(negedge clk);
                chk("held_out_valid", 32'(out_valid), 32'd1);
                chk("held_pending", 32'(pending_count), 32'd4);
                chk("held_in_ready", 32'(in_ready), 32'd0);
                out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");

        // Dead divider: LOAD plus TIMEOUT WAIT cycles before RESULT.
        div_dead = 1'b1;
        push({3'd3, 13'd48}, {3'd3, 13'd16}, {3'b100, 16'h0000});
        wait_start(t0);
        i = 0;
        while (!out_valid && i < 200) begin
            @(negedge clk);
            i++;
        end
        t1 = cyc;
        chk("timeout_latency", 32'(t1 - t0), 32'(TIMEOUT + 1));
        drain("drain_timeout");
        div_dead = 1'b0;

        // Reset mid-WAIT with two pairs queued: nothing may come out afterwards.
        push({3'd3, 13'd48}, {3'd3, 13'd16}, {3'b000, 3'd3, 13'd24});
        push({3'd3, 13'd8},  {3'd3, 13'd8},  {3'b000, 3'd3, 13'd8});
        push({3'd3, 13'd40}, {3'd3, 13'd16}, {3'b000, 3'd3, 13'd20});
        repeat (5) @(negedge clk);
        chk("midwait_busy", 32'(busy), 32'd1);
        chk("midwait_pending", 32'(pending_count), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_pending", 32'(pending_count), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (60) @(negedge clk);
        push({3'd3, 13'h1FD0}, {3'd3, 13'd16}, {3'b000, 3'd3, 13'h1FE8});
        drain("drain_after_reset");

        chk("result_count", 32'(n_out), 32'd12);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
